// File: rtl/ripple_sampler_pkg.sv
// Purpose : shared types and default widths for the ripple-count sampler slice.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package ripple_sampler_pkg;

    // Reader FSM: INIT waits for the first trustworthy sample to use as the
    // reference count; RUN turns every later accepted sample into a delta.
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int unsigned DEF_CNT_W       = 3;
    localparam int unsigned DEF_PEND_W      = 5;
    localparam int unsigned DEF_ACC_W       = 16;
    localparam int unsigned DEF_SYNC_STAGES = 2;

endpackage : ripple_sampler_pkg

// File: rtl/ripple_count_sampler_bus_sync.sv
// Purpose : per-bit flop-chain synchroniser for an asynchronous multi-bit bus.
// Latency : STAGES clk edges from d_in to q_out.
// Backpressure: none; free-running every cycle.
//
// Ports:
//   clk    in   1  system clock, rising edge
//   rst    in   1  synchronous active-high reset, clears every stage to 0
//   d_in   in   W  asynchronous bus
//   q_out  out  W  synchronised bus (last stage)
module bus_sync #(
    parameter int unsigned W      = 3,
    parameter int unsigned STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_in,
    output logic [W-1:0] q_out
);

    logic [STAGES-1:0][W-1:0] sync_q;
    logic [STAGES-1:0][W-1:0] sync_d;

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = d_in;
        for (int i = 1; i < int'(STAGES); i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_out = sync_q[STAGES-1];

endmodule : bus_sync

// File: rtl/ripple_count_sampler.sv
// Purpose : samples an async ripple count, rejects transients, emits modulo deltas + running total.
// Latency : count_in stable at edge N -> delta_valid at N+SYNC_STAGES+2 (filter) / +1 (no filter).
// Backpressure: deltas accumulate in pend while delta_ready=0; saturates at all-ones and sets err.
//
// Ports:
//   clk          in   1       system clock, rising edge
//   rst          in   1       synchronous active-high reset
//   count_in     in   CNT_W   asynchronous ripple count
//   delta_valid  out  1       pending delta available
//   delta_ready  in   1       consumer takes delta this cycle
//   delta        out  PEND_W  counts elapsed since last accepted transfer
//   total        out  ACC_W   running sum of all deltas (wraps)
//   total_wrap   out  1       sticky: total wrapped at least once
//   err          out  1       sticky: pending accumulator saturated
//
// Build option: define RIPPLE_SAMPLER_FILTER_EN to accept a synchronised
// sample only when it matches the previous cycle's sample.
module ripple_count_sampler
    import ripple_sampler_pkg::*;
#(
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned PEND_W      = DEF_PEND_W,
    parameter int unsigned ACC_W       = DEF_ACC_W,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CNT_W-1:0]  count_in,
    output logic              delta_valid,
    input  logic              delta_ready,
    output logic [PEND_W-1:0] delta,
    output logic [ACC_W-1:0]  total,
    output logic              total_wrap,
    output logic              err
);

    localparam int unsigned FILL_W = $clog2(SYNC_STAGES + 1);

    logic [CNT_W-1:0]  s_cnt;

    // Synchroniser warm-up: the chain holds reset zeros for SYNC_STAGES
    // cycles, which must not be mistaken for a real first sample.
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              filled;
    logic              accept;

    logic              acc_vld_q, acc_vld_d;
    logic [CNT_W-1:0]  acc_cnt_q, acc_cnt_d;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  last_cnt_q, last_cnt_d;
    logic [CNT_W-1:0]  d_cnt;
    logic              hs;
    logic [PEND_W-1:0] pend_base;
    logic [PEND_W:0]   pend_sum;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              delta_valid_q, delta_valid_d;
    logic [ACC_W:0]    total_sum;
    logic [ACC_W-1:0]  total_q, total_d;
    logic              total_wrap_q, total_wrap_d;
    logic              err_q, err_d;

`ifdef RIPPLE_SAMPLER_FILTER_EN
    logic [CNT_W-1:0]  prev_q, prev_d;
`endif

    bus_sync #(
        .W      (CNT_W),
        .STAGES (SYNC_STAGES)
    ) u_bus_sync (
        .clk   (clk),
        .rst   (rst),
        .d_in  (count_in),
        .q_out (s_cnt)
    );

    always_comb begin
        // Warm-up counter saturates once the chain holds real data.
        filled = (fill_q == FILL_W'(SYNC_STAGES));
        fill_d = filled ? fill_q : fill_q + FILL_W'(1);

`ifdef RIPPLE_SAMPLER_FILTER_EN
        // A ripple transient rarely lasts two cycles; require two equal samples.
        prev_d = s_cnt;
        accept = filled && (s_cnt == prev_q);
`else
        accept = filled;
`endif

        acc_vld_d = accept;
        acc_cnt_d = accept ? s_cnt : acc_cnt_q;

        state_d    = state_q;
        last_cnt_d = last_cnt_q;
        d_cnt      = '0;
        if (acc_vld_q) begin
            case (state_q)
                INIT: begin
                    last_cnt_d = acc_cnt_q;
                    state_d    = RUN;
                end
                RUN: begin
                    // CNT_W-bit subtraction gives the modulo-2^CNT_W distance,
                    // so a 7 -> 0 roll-over reads as one count.
                    d_cnt      = acc_cnt_q - last_cnt_q;
                    last_cnt_d = acc_cnt_q;
                end
                default: state_d = INIT;
            endcase
        end

        // A transfer this cycle empties pend before the new delta lands, so a
        // simultaneous handshake and count neither loses nor repeats counts.
        hs        = delta_valid_q & delta_ready;
        pend_base = hs ? '0 : pend_q;
        pend_sum  = {1'b0, pend_base} + {{(PEND_W + 1 - CNT_W){1'b0}}, d_cnt};
        err_d     = err_q;
        if (pend_sum[PEND_W]) begin
            pend_d = '1;
            err_d  = 1'b1;
        end else begin
            pend_d = pend_sum[PEND_W-1:0];
        end
        delta_valid_d = (pend_d != '0);

        total_sum    = {1'b0, total_q} + (ACC_W + 1)'(d_cnt);
        total_d      = total_sum[ACC_W-1:0];
        total_wrap_d = total_wrap_q | total_sum[ACC_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_q        <= '0;
            acc_vld_q     <= 1'b0;
            acc_cnt_q     <= '0;
            state_q       <= INIT;
            last_cnt_q    <= '0;
            pend_q        <= '0;
            delta_valid_q <= 1'b0;
            total_q       <= '0;
            total_wrap_q  <= 1'b0;
            err_q         <= 1'b0;
`ifdef RIPPLE_SAMPLER_FILTER_EN
            prev_q        <= '0;
`endif
        end else begin
            fill_q        <= fill_d;
            acc_vld_q     <= acc_vld_d;
            acc_cnt_q     <= acc_cnt_d;
            state_q       <= state_d;
            last_cnt_q    <= last_cnt_d;
            pend_q        <= pend_d;
            delta_valid_q <= delta_valid_d;
            total_q       <= total_d;
            total_wrap_q  <= total_wrap_d;
            err_q         <= err_d;
`ifdef RIPPLE_SAMPLER_FILTER_EN
            prev_q        <= prev_d;
`endif
        end
    end

    assign delta_valid = delta_valid_q;
    assign delta       = pend_q;
    assign total       = total_q;
    assign total_wrap  = total_wrap_q;
    assign err         = err_q;

endmodule : ripple_count_sampler

// File: tb/tb_ripple_count_sampler.sv
// Directed bench for ripple_count_sampler: expected transfers go into a
// scoreboard queue when the count is driven and are popped by a monitor on
// each handshake; totals and sticky flags are tracked by the bench itself.
module tb_ripple_count_sampler;

    localparam int CNT_W  = 3;
    localparam int PEND_W = 5;
    localparam int ACC_W  = 16;
    localparam int SS     = 2;
`ifdef RIPPLE_SAMPLER_FILTER_EN
    localparam int LAT = SS + 2;
`else
    localparam int LAT = SS + 1;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [CNT_W-1:0]  count_in;
    logic              delta_valid;
    logic              delta_ready;
    logic [PEND_W-1:0] delta;
    logic [ACC_W-1:0]  total;
    logic              total_wrap;
    logic              err;

    int unsigned       sb[$];
    int                n_chk  = 0;
    int                n_pass = 0;
    int                n_fail = 0;
    logic [ACC_W-1:0]  exp_total = '0;
    logic              exp_wrap  = 1'b0;
    int                cur = 0;

    always #5 clk = ~clk;

    ripple_count_sampler #(
        .CNT_W       (CNT_W),
        .PEND_W      (PEND_W),
        .ACC_W       (ACC_W),
        .SYNC_STAGES (SS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .count_in    (count_in),
        .delta_valid (delta_valid),
        .delta_ready (delta_ready),
        .delta       (delta),
        .total       (total),
        .total_wrap  (total_wrap),
        .err         (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add_total(input int d);
        logic [ACC_W:0] s;
        s = {1'b0, exp_total} + (ACC_W + 1)'(d);
        exp_total = s[ACC_W-1:0];
        if (s[ACC_W]) exp_wrap = 1'b1;
    endtask

    // Drive a new count; d is the modulo distance it represents.
    task automatic drive(input int v, input int hold, input bit xfer);
        int d;
        d   = (v - cur + 8) % 8;
        cur = v;
        if (xfer) sb.push_back(d);
        add_total(d);
        count_in = CNT_W'(v);
        repeat (hold) step();
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            step();
            n++;
        end
        check(tag, sb.size(), 0);
    endtask

    // Handshake monitor: delta_ready and delta are stable at the falling edge.
    always @(negedge clk) begin
        if (!rst && delta_valid && delta_ready) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $error("FAIL unexpected_xfer: got delta %0d expected no transfer", delta);
            end else begin
                check("xfer_delta", delta, sb.pop_front());
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        count_in    = '0;
        delta_ready = 1'b1;
        repeat (3) step();
        check("rst_valid", delta_valid, 0);
        check("rst_delta", delta, 0);
        check("rst_total", total, 0);
        check("rst_wrap", total_wrap, 0);
        check("rst_err", err, 0);
        rst = 1'b0;

        // 1: first sample is the reference, then three single steps.
        repeat (10) step();
        check("init_no_delta", delta_valid, 0);
        sb.push_back(1);
        add_total(1);
        cur      = 1;
        count_in = 3'd1;
        repeat (LAT) step();
        check("lat_before", delta_valid, 0);
        step();
        check("lat_at", delta_valid, 1);
        repeat (8) step();
        drive(2, 10, 1);
        drive(3, 10, 1);
        drain("t1_drain");
        check("t1_total", total, exp_total);

        // 2: consumer stalls, counts pile up into one transfer of 5.
        delta_ready = 1'b0;
        for (int k = 4; k <= 8; k++) drive(k % 8, 10, 0);
        check("t2_valid", delta_valid, 1);
        check("t2_delta_held", delta, 5);
        sb.push_back(5);
        delta_ready = 1'b1;
        drain("t2_drain");
        check("t2_total", total, exp_total);

        // 3: single steps across the 7 -> 0 roll-over.
        drive(5, 10, 1);
        drive(6, 10, 1);
        drive(7, 10, 1);
        drive(0, 10, 1);
        drive(1, 10, 1);
        drain("t3_drain");
        check("t3_total", total, exp_total);
        check("t3_err", err, 0);

        // 4: one-cycle transient 3 -> 0 -> 4.
        drive(3, 10, 1);
        count_in = 3'd0;
        step();
`ifdef RIPPLE_SAMPLER_FILTER_EN
        drive(4, 10, 1);
`else
        cur = 0;
        sb.push_back(5);
        add_total(5);
        drive(4, 10, 1);
`endif
        drain("t4_drain");
        check("t4_total", total, exp_total);
        check("t4_err", err, 0);

        // 5: 40 steps with no consumer saturate the 5-bit accumulator.
        delta_ready = 1'b0;
        for (int k = 0; k < 40; k++) drive((cur + 1) % 8, 4, 0);
        repeat (10) step();
        check("t5_valid", delta_valid, 1);
        check("t5_delta_sat", delta, 31);
        check("t5_err", err, 1);
        check("t5_total", total, exp_total);
        sb.push_back(31);
        delta_ready = 1'b1;
        drain("t5_drain");
        step();
        check("t5_valid_after", delta_valid, 0);
        check("t5_err_sticky", err, 1);

        // Total roll-over: steps of 7 until the 16-bit total wraps.
        check("wrap_before", total_wrap, 0);
        for (int k = 0; k < 10000 && !exp_wrap; k++) drive((cur + 7) % 8, 4, 1);
        drive((cur + 7) % 8, 4, 1);
        drain("wrap_drain");
        check("wrap_total", total, exp_total);
        check("wrap_flag", total_wrap, 1);

        // 6: reset while a delta is pending and unaccepted.
        delta_ready = 1'b0;
        drive((cur + 1) % 8, 10, 0);
        check("t6_pre_valid", delta_valid, 1);
        rst = 1'b1;
        step();
        check("t6_rst_valid", delta_valid, 0);
        check("t6_rst_total", total, 0);
        check("t6_rst_wrap", total_wrap, 0);
        check("t6_rst_err", err, 0);
        rst         = 1'b0;
        exp_total   = '0;
        exp_wrap    = 1'b0;
        delta_ready = 1'b1;
        repeat (12) step();
        check("t6_first_no_delta", delta_valid, 0);
        check("t6_first_total", total, 0);
        drive((cur + 1) % 8, 10, 1);
        drain("t6_drain");
        check("t6_total", total, exp_total);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_ripple_count_sampler
